fetch_queue: RTL

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register (pipeline0) in the VLIW pipeline. It owns the fetch PC and issues word-aligned requests to instruction memory. Returned instructions are buffered with their PCs in a small in-order prefetch queue. It presents one instruction/PC pair per cycle to decode, and flushes on redirects from branch, jump or exception.

---
 rtl/fetch_queue.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the fetch PC and issues word-aligned requests to instruction memory.
// Every issued PC is remembered in an in-order tag FIFO so that a returning
// instruction word can be paired with its address. Paired {instr, pc} entries
// are buffered in a small in-order prefetch queue whose head is presented to
// decode. A redirect flushes the queue and makes the stage discard every
// response that was already in flight.
//
// Ports:
//   clk             clock, rising edge
//   reset           synchronous, active-high reset
//   stall           decode is not accepting the head entry this cycle
//   redirect_valid  restart fetching at redirect_pc (branch, jump, exception)
//   redirect_pc     new fetch PC (low two bits ignored)
//   imem_req        request strobe, accepted by memory in the same cycle
//   imem_addr       word-aligned request address
//   imem_rvalid     in-order response strobe from memory
//   imem_rdata      instruction word returned by memory
//   out_valid       queue head holds a valid instruction
//   out_instr       head instruction (0 when empty)
//   out_pc          PC of the head instruction (0 when empty)
//   q_count         current queue occupancy
module fetch_queue #(
   parameter int          DEPTH           = 4,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   redirect_valid,
   input  logic [31:0]            redirect_pc,
   output logic                   imem_req,
   output logic [31:0]            imem_addr,
   input  logic                   imem_rvalid,
   input  logic [31:0]            imem_rdata,
   output logic                   out_valid,
   output logic [31:0]            out_instr,
   output logic [31:0]            out_pc,
   output logic [$clog2(DEPTH):0] q_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

   // Prefetch queue storage and control
   logic [31:0]   r_q_instr [DEPTH];
   logic [31:0]   r_q_pc    [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;

   // Fetch side state
   logic [31:0]   r_fetch_pc;
   logic [OW-1:0] r_outstanding;   // every request in flight, stale or not
   logic [OW-1:0] r_drop_cnt;      // in-flight responses that belong to a flushed stream

   // Tag FIFO: PCs of live (non-stale) requests, oldest first
   logic [31:0]   r_tag [MAX_OUTSTANDING];
   logic [TW-1:0] r_tag_rd;
   logic [TW-1:0] r_tag_wr;

   logic w_issue;
   logic w_resp;
   logic w_drop;
   logic w_push;
   logic w_pop;

   function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] ptr);
      return (ptr == TAG_LAST) ? '0 : ptr + TW'(1);
   endfunction

   // Occupancy plus in-flight requests never exceeds DEPTH, which is what
   // guarantees that every live response finds a free queue slot.
   assign w_issue = !reset && !redirect_valid &&
                    (32'(r_outstanding) < MAX_OUTSTANDING) &&
                    ((32'(r_count) + 32'(r_outstanding)) < DEPTH);

   // A response with nothing in flight (e.g. a leftover from before reset)
   // is ignored.
   assign w_resp = imem_rvalid && (r_outstanding != '0);
   assign w_drop = w_resp && (r_drop_cnt != '0);
   assign w_push = w_resp && !w_drop && !redirect_valid;
   assign w_pop  = out_valid && !stall && !redirect_valid;

   assign imem_req  = w_issue;
   assign imem_addr = r_fetch_pc & ~32'h3;

   assign out_valid = (r_count != '0);
   assign out_instr = out_valid ? r_q_instr[r_head] : 32'h0;
   assign out_pc    = out_valid ? r_q_pc[r_head]    : 32'h0;
   assign q_count   = r_count;

   // Queue entries: written only at the tail, no reset needed because the
   // head outputs are gated by out_valid.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (w_push && (r_tail == AW'(gi))) begin
            r_q_instr[gi] <= imem_rdata;
            r_q_pc[gi]    <= r_tag[r_tag_rd];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_tag[r_tag_wr] <= r_fetch_pc & ~32'h3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_tag_rd      <= '0;
         r_tag_wr      <= '0;
      end else begin
         // In-flight accounting continues through redirects: stale requests
         // still occupy a memory slot until their response comes back.
         case ({w_issue, w_resp})
            2'b10:   r_outstanding <= r_outstanding + OW'(1);
            2'b01:   r_outstanding <= r_outstanding - OW'(1);
            default: r_outstanding <= r_outstanding;
         endcase

         if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & ~32'h3;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
            // Everything still in flight after this cycle is stale.
            r_drop_cnt <= r_outstanding - (w_resp ? OW'(1) : OW'(0));
         end else begin
            if (w_issue) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
               r_tag_wr   <= tag_next(r_tag_wr);
            end
            if (w_drop) begin
               r_drop_cnt <= r_drop_cnt - OW'(1);
            end
            if (w_resp && !w_drop) begin
               r_tag_rd <= tag_next(r_tag_rd);
            end
            if (w_push) begin
               r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
               r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Memory must never answer a request that was not made.
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
      !(imem_rvalid && (r_outstanding == '0)));

endmodule
